uart_rx_ctrl: RTL and testbench

- Controller for the 16x-oversampling UART receiver: generates its sample tick from a programmable divisor and absorbs each received byte into a small FIFO.
- Exposes the FIFO to the host as a valid/ready stream, with a sticky overrun flag and a character-timeout flag.
- Sits between the receiver and the register/bus interface; one instance per UART channel.

---
 rtl/uart_rx_ctrl.sv | 166 ++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: sample-tick divider, receive FIFO,
// sticky overrun flag and character-timeout FSM.
module uart_rx_ctrl #(
    parameter int DataWidth   = 8,
    parameter int FifoDepth   = 8,
    parameter int DivWidth    = 16,
    parameter int TimeoutBits = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           enable_i,
    input  logic [DivWidth-1:0]            divisor_i,
    input  logic                           clear_i,
    output logic                           sample_tick_o,
    input  logic                           rx_done_tick_i,
    input  logic [DataWidth-1:0]           rx_data_i,
    output logic                           rx_valid_o,
    input  logic                           rx_ready_i,
    output logic [DataWidth-1:0]           rx_data_o,
    output logic [$clog2(FifoDepth):0]     fifo_count_o,
    output logic                           overrun_o,
    output logic                           timeout_o
);

    localparam int AW = $clog2(FifoDepth);
    localparam int CW = AW + 1;
    localparam int L  = TimeoutBits * 16;
    localparam int TW = $clog2(L);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_COUNT,
        ST_TIMEOUT
    } state_e;

    logic [DivWidth-1:0]  div_cnt_q, div_cnt_d;
    logic                 tick;

    logic [DataWidth-1:0] mem_q [FifoDepth];
    logic [AW-1:0]        wptr_q, wptr_d;
    logic [AW-1:0]        rptr_q, rptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 ovr_q, ovr_d;

    state_e               state_q, state_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;

    logic                 empty, full;
    logic                 push_req, push, pop;

    // Reset gates the tick so every output reads 0 while rst_i is held.
    assign tick = enable_i && !rst_i && (div_cnt_q >= divisor_i);

    always_comb begin
        div_cnt_d = div_cnt_q + DivWidth'(1);
        if (!enable_i || tick) begin
            div_cnt_d = '0;
        end
    end

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(FifoDepth));
    assign push_req = rx_done_tick_i && enable_i && !clear_i;
    assign pop      = !empty && rx_ready_i && !clear_i;
    assign push     = push_req && (!full || pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovr_d   = ovr_q;
        if (clear_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovr_d   = 1'b0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
            if (push_req && full && !pop) begin
                ovr_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        if (clear_i) begin
            state_d = ST_EMPTY;
            tcnt_d  = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    tcnt_d = '0;
                    if (push) begin
                        state_d = ST_COUNT;
                    end
                end
                ST_COUNT, ST_TIMEOUT: begin
                    if (pop && !push && count_q == CW'(1)) begin
                        state_d = ST_EMPTY;
                        tcnt_d  = '0;
                    end else if (push_req || pop) begin
                        state_d = ST_COUNT;
                        tcnt_d  = '0;
                    end else if (state_q == ST_COUNT && tick) begin
                        if (tcnt_q == TW'(L - 1)) begin
                            state_d = ST_TIMEOUT;
                            tcnt_d  = '0;
                        end else begin
                            tcnt_d = tcnt_q + TW'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    tcnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt_q <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            ovr_q     <= 1'b0;
            state_q   <= ST_EMPTY;
            tcnt_q    <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            ovr_q     <= ovr_d;
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= rx_data_i;
        end
    end

    assign sample_tick_o = tick;
    assign rx_valid_o    = !empty;
    assign rx_data_o     = empty ? '0 : mem_q[rptr_q];
    assign fifo_count_o  = count_q;
    assign overrun_o     = ovr_q;
    assign timeout_o     = (state_q == ST_TIMEOUT);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: divider, ordering, overrun,
// timeout, clear and asynchronous reset.
module tb_uart_rx_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        enable_i;
    logic [15:0] divisor_i;
    logic        clear_i;
    logic        sample_tick_o;
    logic        rx_done_tick_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_o;
    logic        rx_ready_i;
    logic [7:0]  rx_data_o;
    logic [3:0]  fifo_count_o;
    logic        overrun_o;
    logic        timeout_o;

    int errors = 0;
    int checks = 0;

    uart_rx_ctrl #(
        .DataWidth   (8),
        .FifoDepth   (8),
        .DivWidth    (16),
        .TimeoutBits (4)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .enable_i       (enable_i),
        .divisor_i      (divisor_i),
        .clear_i        (clear_i),
        .sample_tick_o  (sample_tick_o),
        .rx_done_tick_i (rx_done_tick_i),
        .rx_data_i      (rx_data_i),
        .rx_valid_o     (rx_valid_o),
        .rx_ready_i     (rx_ready_i),
        .rx_data_o      (rx_data_o),
        .fifo_count_o   (fifo_count_o),
        .overrun_o      (overrun_o),
        .timeout_o      (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        rx_done_tick_i = 1'b1;
        rx_data_i      = b;
        step();
        rx_done_tick_i = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cnt"},   fifo_count_o, 0);
        chk({tag, "_valid"}, rx_valid_o, 0);
        chk({tag, "_data"},  rx_data_o, 0);
        chk({tag, "_ovr"},   overrun_o, 0);
        chk({tag, "_tmo"},   timeout_o, 0);
    endtask

    initial begin
        rst_i          = 1'b1;
        enable_i       = 1'b0;
        divisor_i      = 16'd3;
        clear_i        = 1'b0;
        rx_done_tick_i = 1'b0;
        rx_data_i      = 8'h00;
        rx_ready_i     = 1'b0;
        #3;
        chk_all_zero("reset");
        chk("reset_tick", sample_tick_o, 0);
        #9 rst_i = 1'b0;
        step();

        // divisor 3: ticks on cycles 4,8,12,16,20 after enable
        enable_i = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            #1;
            chk("tick_div3", sample_tick_o, (i % 4 == 0));
            step();
        end
        divisor_i = 16'd0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("tick_div0", sample_tick_o, 1);
            step();
        end
        enable_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("tick_dis", sample_tick_o, 0);
            step();
        end
        enable_i  = 1'b1;
        divisor_i = 16'd1000;

        // ordering, with no same-cycle bypass
        rx_done_tick_i = 1'b1;
        rx_data_i      = 8'hA5;
        #1;
        chk("no_bypass_valid", rx_valid_o, 0);
        step();
        rx_done_tick_i = 1'b0;
        push(8'h3C);
        push(8'hFF);
        chk("ord_cnt3", fifo_count_o, 3);
        chk("ord_d0", rx_data_o, 8'hA5);
        rx_ready_i = 1'b1;
        step();
        chk("ord_d1", rx_data_o, 8'h3C);
        chk("ord_cnt2", fifo_count_o, 2);
        step();
        chk("ord_d2", rx_data_o, 8'hFF);
        chk("ord_cnt1", fifo_count_o, 1);
        step();
        chk("ord_cnt0", fifo_count_o, 0);
        chk("ord_valid0", rx_valid_o, 0);
        chk("ord_data0", rx_data_o, 0);
        step();
        chk("ord_ready_empty", fifo_count_o, 0);
        rx_ready_i = 1'b0;

        // overrun: nine pushes into eight entries
        for (int i = 0; i < 8; i++) push(8'(i));
        chk("ovr_full_cnt", fifo_count_o, 8);
        chk("ovr_not_yet", overrun_o, 0);
        push(8'h08);
        chk("ovr_cnt8", fifo_count_o, 8);
        chk("ovr_set", overrun_o, 1);
        rx_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("ovr_drain", rx_data_o, i);
            step();
        end
        rx_ready_i = 1'b0;
        chk("ovr_drained_cnt", fifo_count_o, 0);
        chk("ovr_sticky", overrun_o, 1);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        chk("ovr_cleared", overrun_o, 0);

        // full with simultaneous push and pop
        for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
        rx_done_tick_i = 1'b1;
        rx_data_i      = 8'h18;
        rx_ready_i     = 1'b1;
        step();
        rx_done_tick_i = 1'b0;
        rx_ready_i     = 1'b0;
        chk("pp_full_ovr", overrun_o, 0);
        chk("pp_full_cnt", fifo_count_o, 8);
        chk("pp_full_head", rx_data_o, 8'h11);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        chk("pp_clear_cnt", fifo_count_o, 0);

        // empty with push and pop request: push only
        rx_ready_i     = 1'b1;
        rx_done_tick_i = 1'b1;
        rx_data_i      = 8'h5A;
        step();
        rx_done_tick_i = 1'b0;
        chk("pp_empty_cnt", fifo_count_o, 1);
        chk("pp_empty_data", rx_data_o, 8'h5A);
        step();
        rx_ready_i = 1'b0;
        chk("pp_empty_pop", fifo_count_o, 0);

        // timeout after 64 ticks with divisor 0
        divisor_i = 16'd0;
        push(8'h77);
        repeat (63) step();
        chk("tmo_before", timeout_o, 0);
        step();
        chk("tmo_rise", timeout_o, 1);
        push(8'h78);
        chk("tmo_push_clr", timeout_o, 0);
        chk("tmo_push_cnt", fifo_count_o, 2);
        repeat (64) step();
        chk("tmo_rise2", timeout_o, 1);
        rx_ready_i = 1'b1;
        step();
        rx_ready_i = 1'b0;
        chk("tmo_pop_clr", timeout_o, 0);
        chk("tmo_pop_head", rx_data_o, 8'h78);
        repeat (64) step();
        chk("tmo_rise3", timeout_o, 1);
        rx_ready_i = 1'b1;
        step();
        rx_ready_i = 1'b0;
        chk("tmo_last_clr", timeout_o, 0);
        chk("tmo_last_valid", rx_valid_o, 0);
        repeat (70) step();
        chk("tmo_empty_idle", timeout_o, 0);

        // clear beats push and pop, drops flags
        for (int i = 0; i < 9; i++) push(8'(8'h20 + i));
        rx_ready_i = 1'b1;
        repeat (3) step();
        rx_ready_i = 1'b0;
        chk("clr_pre_cnt", fifo_count_o, 5);
        repeat (64) step();
        chk("clr_pre_tmo", timeout_o, 1);
        chk("clr_pre_ovr", overrun_o, 1);
        clear_i        = 1'b1;
        rx_done_tick_i = 1'b1;
        rx_data_i      = 8'h99;
        rx_ready_i     = 1'b1;
        step();
        clear_i        = 1'b0;
        rx_done_tick_i = 1'b0;
        rx_ready_i     = 1'b0;
        chk_all_zero("clr");
        push(8'h42);
        chk("clr_after_cnt", fifo_count_o, 1);
        chk("clr_after_data", rx_data_o, 8'h42);

        // async reset with three bytes queued
        push(8'h43);
        push(8'h44);
        chk("rst_pre_cnt", fifo_count_o, 3);
        #2 rst_i = 1'b1;
        #1;
        chk_all_zero("rst");
        chk("rst_tick", sample_tick_o, 0);
        #3 rst_i = 1'b0;
        step();
        push(8'hC3);
        chk("rst_after_cnt", fifo_count_o, 1);
        chk("rst_after_data", rx_data_o, 8'hC3);
        chk("rst_after_valid", rx_valid_o, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
